// File: rtl/controlador_janela_if.sv
// Command/status bundle between the measurement sequencer and its host.
// The host (master) drives the requests and the counter carry; the sequencer (slave) returns the pulses and flags.
interface controlador_janela_if;
    logic iniciar;
    logic parar;
    logic continuo;
    logic overflow_in;
    logic zera_contador;
    logic habilita_contagem;
    logic armazena;
    logic limpar;
    logic ocupado;
    logic estouro;

    modport master (
        output iniciar, parar, continuo, overflow_in,
        input  zera_contador, habilita_contagem, armazena, limpar, ocupado, estouro
    );

    modport slave (
        input  iniciar, parar, continuo, overflow_in,
        output zera_contador, habilita_contagem, armazena, limpar, ocupado, estouro
    );
endinterface

// File: rtl/controlador_janela.sv
// Gate-window sequencer for a 5-digit BCD frequency counter: clear, count for GATE_CYCLES, then store or clear the display.
// Every output is a flop loaded from the decode of the next state, so no input reaches an output combinationally.
module controlador_janela #(
    parameter int GATE_CYCLES = 1000,
    parameter int HOLD_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    controlador_janela_if.slave   bus
);
    localparam int CW = $clog2(GATE_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_ULT  = CW'(GATE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ULT = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [2:0] {OCIOSO, ZERA, JANELA, FIM, ESPERA} estado_t;

    estado_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          estouro_q, estouro_d;
    logic          zera_q, zera_d;
    logic          hab_q, hab_d;
    logic          arm_q, arm_d;
    logic          lim_q, lim_d;
    logic          ocup_q, ocup_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        case (state_q)
            OCIOSO: if (bus.iniciar && !bus.parar) state_d = ZERA;
            ZERA: begin
                cnt_d   = '0;
                state_d = JANELA;
            end
            JANELA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_ULT) state_d = FIM;
            end
            FIM: begin
                hold_d = '0;
                if (HOLD_CYCLES > 0) state_d = ESPERA;
                else                 state_d = bus.continuo ? ZERA : OCIOSO;
            end
            ESPERA: begin
                hold_d = hold_q + HW'(1);
                if (hold_q == HOLD_ULT) state_d = bus.continuo ? ZERA : OCIOSO;
            end
            default: state_d = OCIOSO;
        endcase
        // Abort wins over every sequencing decision above.
        if (state_q != OCIOSO && bus.parar) state_d = OCIOSO;

        estouro_d = estouro_q;
        if (state_q == JANELA && bus.overflow_in) estouro_d = 1'b1;
        if (state_d == ZERA)                      estouro_d = 1'b0;

        zera_d = (state_d == ZERA);
        hab_d  = (state_d == JANELA);
        arm_d  = (state_d == FIM) && !estouro_d;
        lim_d  = (state_d == FIM) &&  estouro_d;
        ocup_d = (state_d != OCIOSO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= OCIOSO;
            cnt_q     <= '0;
            hold_q    <= '0;
            estouro_q <= 1'b0;
            zera_q    <= 1'b0;
            hab_q     <= 1'b0;
            arm_q     <= 1'b0;
            lim_q     <= 1'b0;
            ocup_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            estouro_q <= estouro_d;
            zera_q    <= zera_d;
            hab_q     <= hab_d;
            arm_q     <= arm_d;
            lim_q     <= lim_d;
            ocup_q    <= ocup_d;
        end
    end

    assign bus.zera_contador     = zera_q;
    assign bus.habilita_contagem = hab_q;
    assign bus.armazena          = arm_q;
    assign bus.limpar            = lim_q;
    assign bus.ocupado           = ocup_q;
    assign bus.estouro           = estouro_q;
endmodule

// File: tb/tb_controlador_janela.sv
// Bench for controlador_janela: two instances (4/2 and 1/0) share one stimulus stream and are checked each cycle
// against a model that tracks each measurement as an offset from its clear cycle.
module tb_controlador_janela;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    controlador_janela_if ia ();
    controlador_janela_if ib ();

    controlador_janela #(.GATE_CYCLES(4), .HOLD_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    controlador_janela #(.GATE_CYCLES(1), .HOLD_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    int checks = 0;
    int errors = 0;
    int gc[2] = '{4, 1};
    int hc[2] = '{2, 0};
    bit act[2];
    int k[2];
    bit est[2];
    logic ini, par, con, ovf;

    task automatic drive(input logic r, input logic i, input logic p, input logic c, input logic o);
        rst = r; ini = i; par = p; con = c; ovf = o;
        ia.iniciar = i; ia.parar = p; ia.continuo = c; ia.overflow_in = o;
        ib.iniciar = i; ib.parar = p; ib.continuo = c; ib.overflow_in = o;
    endtask

    // k is the cycle offset from the clear pulse: 0 clear, 1..G window, G+1 store/clear, then H hold cycles.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                act[m] = 0;
                est[m] = 0;
            end else if (act[m]) begin
                if (ovf && k[m] >= 1 && k[m] <= gc[m]) est[m] = 1;
                if (par) act[m] = 0;
                else begin
                    k[m]++;
                    if (k[m] == gc[m] + hc[m] + 2) begin
                        if (con) begin k[m] = 0; est[m] = 0; end
                        else act[m] = 0;
                    end
                end
            end else if (ini && !par) begin
                act[m] = 1;
                k[m]   = 0;
                est[m] = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input int m, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[dut%0d] t=%0t observed=%b expected=%b", tag, m, $time, obs, exp);
        end
    endtask

    task automatic compare();
        logic [5:0] obs[2];
        logic [5:0] exp;
        obs[0] = {ia.zera_contador, ia.habilita_contagem, ia.armazena, ia.limpar, ia.ocupado, ia.estouro};
        obs[1] = {ib.zera_contador, ib.habilita_contagem, ib.armazena, ib.limpar, ib.ocupado, ib.estouro};
        for (int m = 0; m < 2; m++) begin
            exp[5] = act[m] && k[m] == 0;
            exp[4] = act[m] && k[m] >= 1 && k[m] <= gc[m];
            exp[3] = act[m] && k[m] == gc[m] + 1 && !est[m];
            exp[2] = act[m] && k[m] == gc[m] + 1 &&  est[m];
            exp[1] = act[m];
            exp[0] = est[m];
            chk("zera_contador",     m, obs[m][5], exp[5]);
            chk("habilita_contagem", m, obs[m][4], exp[4]);
            chk("armazena",          m, obs[m][3], exp[3]);
            chk("limpar",            m, obs[m][2], exp[2]);
            chk("ocupado",           m, obs[m][1], exp[1]);
            chk("estouro",           m, obs[m][0], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        compare();
    endtask

    initial begin
        drive(1, 0, 0, 0, 0);
        tick(); tick();
        // single measurement
        drive(0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0); repeat (12) tick();
        // continuous mode, then let it drain to idle
        drive(0, 1, 0, 1, 0); tick();
        drive(0, 0, 0, 1, 0); repeat (16) tick();
        drive(0, 0, 0, 0, 0); repeat (12) tick();
        // overflow in cycle 3 with continuous repeat
        drive(0, 1, 0, 1, 0); tick();
        drive(0, 0, 0, 1, 0); tick(); tick();
        drive(0, 0, 0, 1, 1); tick();
        drive(0, 0, 0, 1, 0); repeat (10) tick();
        drive(0, 0, 0, 0, 0); repeat (12) tick();
        // abort in cycle 3, restart in cycle 5
        drive(0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0); tick(); tick();
        drive(0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0); repeat (12) tick();
        // iniciar held high with a reset mid-window
        for (int c = 0; c <= 20; c++) begin
            drive(c == 4, 1, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0); repeat (12) tick();
        // randomized traffic
        repeat (3000) begin
            drive($urandom_range(99) == 0, $urandom_range(3) == 0, $urandom_range(19) == 0,
                  $urandom_range(2) != 0, $urandom_range(9) == 0);
            tick();
        end
        drive(0, 0, 0, 0, 0); repeat (12) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
